timer_ctrl: RTL
===============

Name: timer_ctrl

Overview:
- Sequencing controller for the minutes:seconds countdown timer datapath, which is a cascade of loadable BCD down-counters (mod-10/mod-6 stages) with loadn, enable and zero flags.
- Collects a 4-digit BCD entry from the keypad and loads it into the timer.
- Issues one-cycle count-enable pulses at the second rate and handles start, pause, door interlock and expiry.
- Drives the magnetron-on and done indicators.

Parameters:
- TICK_DIV, 50_000_000: clock cycles per timer decrement (1 s at 50 MHz); minimum 2.
- CNT_W, 26: prescaler width; must satisfy 2^CNT_W >= TICK_DIV.

Ports:
- clock  in  1  system clock; all logic on posedge.
- clr  in  1  synchronous, active-high reset.
- key_valid  in  1  one-cycle strobe; key_data is valid.
- key_data  in  4  BCD digit from the keypad; values 10-15 are ignored.
- start  in  1  start/resume request, level sampled each cycle.
- stop  in  1  pause/cancel request, level sampled each cycle.
- door_closed  in  1  interlock; 1 = door closed.
- timer_zero  in  1  all timer digits are zero (AND of the stage zero flags).
- load_data  out  16  BCD entry {mm_tens, mm_ones, ss_tens, ss_ones} driven to the timer data inputs.
- loadn  out  1  active-low parallel load to the timer.
- enable  out  1  one-cycle decrement pulse to the timer.
- mag_on  out  1  high only in RUN.
- done  out  1  high only in DONE.
- state  out  3  current state encoding, for display and debug.

Behaviour:
- Reset (clr=1 at posedge), all outputs registered:
  - state=IDLE, load_data=0, loadn=1, enable=0, mag_on=0, done=0, prescaler=0.
- States: IDLE, LOAD, RUN, PAUSE, DONE.
- Input priority within a cycle: clr > door open > stop > start > key_valid.
- IDLE:
  - key_valid with key_data<=9: load_data <= {load_data[11:0], key_data}, i.e. shift left one digit; the oldest digit is dropped.
  - key_data>9: no change.
  - Digit values are not range-checked against mod-6 positions; the timer datapath owns that.
  - start & door_closed & load_data!=0 -> LOAD.
  - start with load_data==0 or the door open: ignored, stay in IDLE.
  - stop clears load_data to 0.
- LOAD:
  - Exactly 1 cycle with loadn=0 and enable=0; prescaler <= 0.
  - Then -> RUN unconditionally, unless the door opens, which goes -> PAUSE.
  - The timer holds the loaded value from the first RUN cycle on.
- RUN (mag_on=1):
  - Prescaler increments each cycle.
  - When prescaler==TICK_DIV-1: prescaler <= 0 and enable=1 for that one cycle, but only if timer_zero==0.
  - If timer_zero==1 in RUN -> DONE. No enable is ever issued while timer_zero=1; this prevents the 0->9 wrap.
  - !door_closed or stop -> PAUSE. The prescaler value is held, no enable is issued that cycle, and mag_on drops the next cycle.
- PAUSE:
  - Prescaler and timer frozen; loadn=1, enable=0.
  - start & door_closed -> RUN, resuming from the held prescaler value with no reload.
  - stop -> IDLE with load_data cleared.
  - key_valid is ignored.
- DONE (done=1):
  - Leaves -> IDLE on stop, on a door open, or on key_valid.
  - load_data is retained so that a start press after returning to IDLE reruns the same time.
- enable and loadn=0 are never asserted in the same cycle.
- clr mid-RUN returns to IDLE within the same edge; mag_on=0 on the next cycle.

Decomposition:
- Package timer_pkg:
  - state enum/localparams IDLE=0, LOAD=1, RUN=2, PAUSE=3, DONE=4;
  - DIGIT_W=4, NUM_DIGITS=4;
  - default TICK_DIV.
- Sub-module tick_prescaler:
  - inputs: clock, clr, run, restart;
  - output: tick;
  - counter 0..TICK_DIV-1, holds while run=0, zeroed by restart.
- The FSM and the entry shift register stay in timer_ctrl.

Test Plan:
- All scenarios use TICK_DIV=4.
- Keys 1,3,0 then start with door closed -> load_data=16'h0130; loadn low for 1 cycle; then enable pulses every 4th cycle while in RUN; mag_on=1.
- Run with a model timer preloaded at 0001 -> one enable pulse, then timer_zero=1 -> DONE with done=1 and mag_on=0; no further enable pulses.
- Door opened 2 cycles after a tick in RUN -> PAUSE, no enable for 20 cycles. Door closed + start -> next enable pulse 2 cycles after re-entering RUN (prescaler held).
- start with load_data=0, and separately with the door open -> state stays IDLE; loadn stays 1.
- start and stop asserted together in IDLE with entry 0045 -> stop wins: load_data=0, state IDLE. Key 11 -> load_data unchanged.
- clr asserted mid-RUN -> next cycle: state=IDLE, all outputs at reset values. Five keys 1..5 -> load_data=16'h2345.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types and constants for the countdown timer sequencing controller.
package timer_pkg;

    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned DATA_W     = DIGIT_W * NUM_DIGITS;
    localparam int unsigned STATE_W    = 3;

    localparam int unsigned TICK_DIV_DEFAULT = 50_000_000;
    localparam int unsigned CNT_W_DEFAULT    = 26;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        PAUSE = 3'd3,
        DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/timer_ctrl_if.sv
// Keypad/control/timer-datapath signal bundle for timer_ctrl.
//   slave  : the controller (consumes keypad/controls/timer_zero, drives timer controls)
//   master : the environment (keypad, buttons, door switch, timer datapath)
interface timer_ctrl_if;
    import timer_pkg::*;

    logic               key_valid;
    logic [DIGIT_W-1:0] key_data;
    logic               start;
    logic               stop;
    logic               door_closed;
    logic               timer_zero;
    logic [DATA_W-1:0]  load_data;
    logic               loadn;
    logic               enable;
    logic               mag_on;
    logic               done;
    logic [STATE_W-1:0] state;

    modport slave (
        input  key_valid, key_data, start, stop, door_closed, timer_zero,
        output load_data, loadn, enable, mag_on, done, state
    );

    modport master (
        output key_valid, key_data, start, stop, door_closed, timer_zero,
        input  load_data, loadn, enable, mag_on, done, state
    );

endinterface

// File: rtl/tick_prescaler.sv
// Second-rate prescaler: counts 0..TICK_DIV-1 while run=1, holds while run=0,
// zeroed by restart.
//   clock, clr : clock and synchronous active-high reset
//   run        : advance the counter this cycle
//   restart    : force the counter to zero (wins over run)
//   tick       : combinational, high on the run cycle where the counter wraps
module tick_prescaler #(
    parameter int unsigned TICK_DIV = 50_000_000,
    parameter int unsigned CNT_W    = 26
) (
    input  logic clock,
    input  logic clr,
    input  logic run,
    input  logic restart,
    output logic tick
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = run && (cnt_q == CNT_W'(TICK_DIV - 1));

    // Next count: restart > wrap on tick > increment > hold
    always_comb begin
        cnt_d = cnt_q;
        if (restart) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (clr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/timer_ctrl.sv
// Sequencing controller for the mm:ss BCD countdown timer: collects a 4-digit
// keypad entry, loads it into the timer, issues second-rate decrement pulses and
// handles pause, door interlock and expiry.
//   clock, clr : clock and synchronous active-high reset
//   bus        : timer_ctrl_if.slave (keypad, start/stop, door, timer_zero in;
//                load_data, loadn, enable, mag_on, done, state out, all registered)
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT,
    parameter int unsigned CNT_W    = CNT_W_DEFAULT
) (
    input  logic         clock,
    input  logic         clr,
    timer_ctrl_if.slave  bus
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] load_data_q, load_data_d;
    logic              loadn_q, enable_q, mag_on_q, done_q;
    logic              enable_d;
    logic              run_c, restart_c, tick_c;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV),
        .CNT_W    (CNT_W)
    ) u_prescaler (
        .clock   (clock),
        .clr     (clr),
        .run     (run_c),
        .restart (restart_c),
        .tick    (tick_c)
    );

    // Next-state, entry register and decrement-pulse logic
    always_comb begin
        state_d     = state_q;
        load_data_d = load_data_q;
        enable_d    = 1'b0;
        run_c       = 1'b0;
        restart_c   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.stop) begin
                    load_data_d = '0;
                end else if (bus.start && bus.door_closed && (load_data_q != '0)) begin
                    state_d = LOAD;
                end else if (bus.key_valid && (bus.key_data <= DIGIT_W'(9))) begin
                    // Shift the new digit in at the seconds-ones position
                    load_data_d = {load_data_q[DATA_W-DIGIT_W-1:0], bus.key_data};
                end
            end
            LOAD: begin
                restart_c = 1'b1;
                state_d   = bus.door_closed ? RUN : PAUSE;
            end
            RUN: begin
                if (!bus.door_closed || bus.stop) begin
                    // Prescaler frozen and no pulse on the pausing cycle
                    state_d = PAUSE;
                end else if (bus.timer_zero) begin
                    // Never pulse at zero, so the timer cannot wrap to 9
                    state_d = DONE;
                end else begin
                    run_c    = 1'b1;
                    enable_d = tick_c;
                end
            end
            PAUSE: begin
                if (bus.stop) begin
                    state_d     = IDLE;
                    load_data_d = '0;
                end else if (bus.start && bus.door_closed) begin
                    state_d = RUN;
                end
            end
            DONE: begin
                if (bus.stop || !bus.door_closed || bus.key_valid) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; indicators follow the state being entered
    always_ff @(posedge clock) begin
        if (clr) begin
            state_q     <= IDLE;
            load_data_q <= '0;
            loadn_q     <= 1'b1;
            enable_q    <= 1'b0;
            mag_on_q    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            load_data_q <= load_data_d;
            loadn_q     <= (state_d != LOAD);
            enable_q    <= enable_d;
            mag_on_q    <= (state_d == RUN);
            done_q      <= (state_d == DONE);
        end
    end

    assign bus.load_data = load_data_q;
    assign bus.loadn     = loadn_q;
    assign bus.enable    = enable_q;
    assign bus.mag_on    = mag_on_q;
    assign bus.done      = done_q;
    assign bus.state     = state_q;

endmodule
